// File: rtl/nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width
// and the index-width helper.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-nibble build still needs a 1-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit ripple-carry slice, reused once per nibble by
// the serial adder.
module nibble_add4
    import nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: accepts operands over valid/ready, adds one
// nibble per clock through a shared 4-bit slice, then holds the result.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_cin,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_cout,
    output logic             io_busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);

    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end

    state_e              state;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    sum_reg;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    assign a_nib = a_reg[int'(idx) * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_reg[int'(idx) * NIBBLE_W +: NIBBLE_W];

    nibble_add4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // The result registers double as the output; they keep the last result
    // after the handshake until the next operation is accepted.
    assign io_out_sum  = sum_reg;
    assign io_out_cout = carry;

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: all state uses non-blocking assignments and is cleared by the async reset.
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            carry        <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            io_out_valid <= 1'b0;
            io_in_ready  <= 1'b1;
            io_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        a_reg       <= io_in_a;
                        b_reg       <= io_in_b;
                        carry       <= io_in_cin;
                        idx         <= '0;
                        sum_reg     <= '0;
                        state       <= RUN;
                        io_in_ready <= 1'b0;
                        io_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_reg[int'(idx) * NIBBLE_W +: NIBBLE_W] <= slice_sum;
                    carry <= slice_cout;
                    if (idx == IDX_W'(NIBBLES - 1)) begin
                        state        <= DONE;
                        io_out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        state        <= IDLE;
                        io_out_valid <= 1'b0;
                        io_in_ready  <= 1'b1;
                        io_busy      <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    io_out_valid <= 1'b0;
                    io_in_ready  <= 1'b1;
                    io_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 16-bit and a 4-bit instance checked every
// cycle against an arithmetic operation model, plus directed literal cases.
module tb_nibble_serial_adder;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Index 0 drives the WIDTH=16 instance, index 1 the WIDTH=4 instance.
    logic        iv[2];
    logic        ic[2];
    logic        ordy[2];
    logic [15:0] ia[2];
    logic [15:0] ib[2];

    logic        ir0, ov0, oc0, bz0;
    logic [15:0] os0;
    logic        ir1, ov1, oc1, bz1;
    logic [3:0]  os1;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (iv[0]),
        .io_in_ready  (ir0),
        .io_in_a      (ia[0]),
        .io_in_b      (ib[0]),
        .io_in_cin    (ic[0]),
        .io_out_valid (ov0),
        .io_out_ready (ordy[0]),
        .io_out_sum   (os0),
        .io_out_cout  (oc0),
        .io_busy      (bz0)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (iv[1]),
        .io_in_ready  (ir1),
        .io_in_a      (ia[1][3:0]),
        .io_in_b      (ib[1][3:0]),
        .io_in_cin    (ic[1]),
        .io_out_valid (ov1),
        .io_out_ready (ordy[1]),
        .io_out_sum   (os1),
        .io_out_cout  (oc1),
        .io_busy      (bz1)
    );

    logic        o_valid[2];
    logic        o_ready[2];
    logic        o_busy[2];
    logic        o_cout[2];
    logic [15:0] o_sum[2];

    always_comb begin
        o_valid[0] = ov0; o_ready[0] = ir0; o_busy[0] = bz0; o_cout[0] = oc0; o_sum[0] = os0;
        o_valid[1] = ov1; o_ready[1] = ir1; o_busy[1] = bz1; o_cout[1] = oc1; o_sum[1] = {12'h000, os1};
    end

    function automatic int width_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[w%0d] t=%0t: got %h, expected %h", name, width_of(k), $time, act, exp);
        end
    endtask

    // Operation-level model: an accepted operation's result is the plain
    // integer A+B+Cin; it becomes visible WIDTH/4 cycles after acceptance and
    // stays until the consumer takes it.
    bit          m_busy[2];
    int          m_cnt[2];
    int          m_done[2];
    logic [16:0] m_exp[2];
    logic [16:0] m_last[2];

    always @(posedge clock or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic [16:0] mask;
            w    = width_of(k);
            mask = (17'd1 << w) - 17'd1;
            if (!reset) begin
                m_busy[k] = 1'b0;
                m_cnt[k]  = 0;
                m_last[k] = '0;
            end else if (!m_busy[k]) begin
                if (iv[k]) begin
                    m_exp[k]  = ({1'b0, ia[k]} & mask) + ({1'b0, ib[k]} & mask) + {16'h0, ic[k]};
                    m_busy[k] = 1'b1;
                    m_cnt[k]  = 0;
                end
            end else if (m_cnt[k] < w / 4) begin
                m_cnt[k]++;
            end else if (ordy[k]) begin
                m_busy[k] = 1'b0;
                m_last[k] = m_exp[k];
                m_done[k]++;
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic [16:0] mask;
            logic        exp_valid;
            logic [16:0] shown;
            w         = width_of(k);
            mask      = (17'd1 << w) - 17'd1;
            exp_valid = m_busy[k] && (m_cnt[k] == w / 4);
            check("out_valid", k, 32'(o_valid[k]), 32'(exp_valid));
            check("in_ready", k, 32'(o_ready[k]), 32'(!m_busy[k]));
            check("busy", k, 32'(o_busy[k]), 32'(m_busy[k]));
            if (exp_valid || !m_busy[k]) begin
                shown = exp_valid ? m_exp[k] : m_last[k];
                check("sum", k, 32'(o_sum[k]), 32'(shown & mask));
                check("cout", k, 32'(o_cout[k]), 32'(shown[w]));
            end
        end
    end

    task automatic start_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clock);
        iv[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        ic[k] = c;
        @(negedge clock);
        iv[k] = 1'b0;
        ia[k] = 16'($urandom);
        ib[k] = 16'($urandom);
        ic[k] = 1'($urandom);
    endtask

    // Called on the negedge right after the acceptance edge; returns the
    // number of edges until out_valid is seen, bounded.
    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!o_valid[k] && lat < 64) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 0, 32'(ov0), 32'd0);
        check({tag, "_ready"}, 0, 32'(ir0), 32'd1);
        check({tag, "_busy"}, 0, 32'(bz0), 32'd0);
        check({tag, "_sum"}, 0, 32'(os0), 32'h0);
        check({tag, "_cout"}, 0, 32'(oc0), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        int cycles;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ic[k] = 1'b0; ordy[k] = 1'b1;
            ia[k] = '0;   ib[k] = '0;
            m_done[k] = 0;
        end

        // Reset held from time zero, released mid-cycle.
        repeat (2) @(negedge clock);
        check_reset_values("por");
        #1 reset = 1'b1;

        // Reset asserted mid-clock must clear outputs without an edge.
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clock);
        #1 reset = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (ov0) seen++;
        end
        check("idle_no_valid", 0, 32'(seen), 32'd0);

        // Basic add and full carry chains.
        start_op(0, 16'h1234, 16'h4321, 1'b0);
        wait_valid(0, lat);
        check("basic_latency", 0, 32'(lat), 32'd4);
        check("basic_sum", 0, 32'(os0), 32'h5555);
        check("basic_cout", 0, 32'(oc0), 32'd0);
        @(negedge clock);
        check("basic_valid_drop", 0, 32'(ov0), 32'd0);
        check("basic_sum_held", 0, 32'(os0), 32'h5555);

        start_op(0, 16'hFFFF, 16'h0001, 1'b0);
        wait_valid(0, lat);
        check("chain1_sum", 0, 32'(os0), 32'h0000);
        check("chain1_cout", 0, 32'(oc0), 32'd1);
        @(negedge clock);

        start_op(0, 16'hFFFF, 16'hFFFF, 1'b1);
        wait_valid(0, lat);
        check("chain2_sum", 0, 32'(os0), 32'hFFFF);
        check("chain2_cout", 0, 32'(oc0), 32'd1);
        @(negedge clock);

        // Backpressure: result held, new operands offered but not taken.
        ordy[0] = 1'b0;
        start_op(0, 16'hA5A5, 16'h5A5A, 1'b1);
        wait_valid(0, lat);
        iv[0] = 1'b1; ia[0] = 16'h0102; ib[0] = 16'h0304; ic[0] = 1'b0;
        repeat (10) begin
            @(negedge clock);
            check("bp_valid", 0, 32'(ov0), 32'd1);
            check("bp_ready", 0, 32'(ir0), 32'd0);
            check("bp_sum", 0, 32'(os0), 32'h0000);
            check("bp_cout", 0, 32'(oc0), 32'd1);
        end
        ordy[0] = 1'b1;
        @(negedge clock);
        check("bp_release_valid", 0, 32'(ov0), 32'd0);
        check("bp_release_ready", 0, 32'(ir0), 32'd1);
        @(negedge clock);
        iv[0] = 1'b0;
        check("bp_next_busy", 0, 32'(bz0), 32'd1);
        wait_valid(0, lat);
        check("bp_next_latency", 0, 32'(lat), 32'd4);
        check("bp_next_sum", 0, 32'(os0), 32'h0406);
        check("bp_next_cout", 0, 32'(oc0), 32'd0);
        @(negedge clock);

        // Reset in the middle of RUN abandons the operation.
        start_op(0, 16'h0F0F, 16'h00F1, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check_reset_values("mid_run_rst");
        @(negedge clock);
        #1 reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (ov0) seen++;
        end
        check("abandoned_no_valid", 0, 32'(seen), 32'd0);
        start_op(0, 16'h0003, 16'h0004, 1'b1);
        wait_valid(0, lat);
        check("after_rst_latency", 0, 32'(lat), 32'd4);
        check("after_rst_sum", 0, 32'(os0), 32'h0008);
        check("after_rst_cout", 0, 32'(oc0), 32'd0);
        @(negedge clock);

        // Randomized traffic on both instances with random backpressure.
        seen   = m_done[1];
        cycles = 0;
        while ((m_done[1] - seen) < 1000 && cycles < 20000) begin
            @(negedge clock);
            cycles++;
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
                ia[k]   = 16'($urandom);
                ib[k]   = 16'($urandom);
                ic[k]   = 1'($urandom);
            end
        end
        check("random_w4_ops_done", 1, 32'((m_done[1] - seen) >= 1000), 32'd1);
        for (int k = 0; k < 2; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (8) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential wide adder for the examples tree. Takes WIDTH-bit operands over a valid/ready handshake and adds them one 4-bit nibble per clock.
- The carry between nibbles is held in a register, and each nibble-cycle's carry-out feeds the next nibble-cycle's carry-in.
- Upstream stage is any operand producer. Downstream stage is a result consumer with backpressure.
- Trades latency for area: one 4-bit slice is reused instead of a WIDTH-bit ripple chain.

Parameters:
- WIDTH, 16, operand and result width. Must be a multiple of 4 and at least 4; elaboration error otherwise.
- NIBBLES, WIDTH/4, derived and not overridable. Number of RUN cycles per operation.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  1  operand beat valid.
- io_in_ready  out  1  block can accept operands.
- io_in_a  in  WIDTH  operand A.
- io_in_b  in  WIDTH  operand B.
- io_in_cin  in  1  carry into bit 0.
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  consumer accepts result.
- io_out_sum  out  WIDTH  A+B+Cin modulo 2^WIDTH.
- io_out_cout  out  1  carry out of bit WIDTH-1.
- io_busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; all state is cleared immediately when reset goes low, independent of clock.
- Reset values:
  - state = IDLE, nibble index = 0, carry register = 0.
  - Operand registers = 0, sum register = 0.
  - io_out_valid = 0, io_out_sum = 0, io_out_cout = 0, io_busy = 0, io_in_ready = 1.
- States: IDLE, RUN, DONE. Two-bit encoding from the shared package.
- IDLE:
  - io_in_ready = 1.
  - On io_in_valid & io_in_ready at a rising edge: latch io_in_a, io_in_b; carry register <= io_in_cin; index <= 0; sum register <= 0; go to RUN.
- RUN:
  - io_in_ready = 0; io_in_valid is ignored.
  - Each cycle the slice adds a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry register, where i = index.
  - sum register nibble i <= slice sum; carry register <= slice cout.
  - If index == NIBBLES-1, go to DONE; otherwise index <= index+1.
  - Exactly NIBBLES cycles are spent in RUN.
- DONE:
  - io_out_valid = 1. io_out_sum = sum register; io_out_cout = carry register.
  - Outputs are held stable while io_out_ready = 0, for any number of cycles.
  - On io_out_valid & io_out_ready: go to IDLE. io_out_valid drops the next cycle; sum/cout keep their last value.
- Latency: acceptance edge at cycle 0 gives io_out_valid high from cycle NIBBLES onward.
  - WIDTH=16: valid is visible 4 cycles after acceptance.
  - WIDTH=4: single RUN cycle, valid 1 cycle after acceptance.
- Throughput: at most one operation per NIBBLES+2 cycles, with io_out_ready tied high. Operations never overlap; io_in_ready = 0 in DONE even if io_out_ready = 1.
- Input stability: io_in_a/io_in_b/io_in_cin changes after acceptance have no effect.
- Arithmetic boundaries:
  - Full wrap-around is modulo 2^WIDTH, with the overflow bit reported only on io_out_cout.
  - No signed interpretation.
- Reset mid-operation (RUN or DONE): the operation is abandoned, all outputs return to reset values, and no result is emitted.
- io_busy = (state != IDLE).

Decomposition:
- Shared package nibble_serial_pkg:
  - state enum IDLE=0, RUN=1, DONE=2;
  - constant NIBBLE_W=4;
  - index width function clog2(NIBBLES), minimum 1.
- Sub-module nibble_add4: purely combinational 4-bit slice.
  - Ports a[3:0], b[3:0], cin → sum[3:0], cout.
  - Bitwise full-adder ripple.
  - Instantiated once; the nibble mux selects its inputs.
- Top module holds the FSM, index counter, carry register, operand and sum registers.

Test Plan:
- Reset/idle: assert reset low mid-clock → all outputs at reset values immediately, io_in_ready=1; release reset, no valid → io_out_valid stays 0 for 20 cycles.
- Basic add, WIDTH=16: A=0x1234, B=0x4321, Cin=0 accepted at cycle 0 → io_out_valid at cycle 4, sum=0x5555, cout=0; io_in_ready=0 during cycles 1-4.
- Full carry chain: A=0xFFFF, B=0x0001, Cin=0 → sum=0x0000, cout=1. Also A=0xFFFF, B=0xFFFF, Cin=1 → sum=0xFFFF, cout=1.
- Backpressure: io_out_ready=0 for 10 cycles in DONE while io_in_valid=1 with new operands → sum/cout stable, nothing accepted. Raise ready → one handshake, IDLE next cycle, new operands accepted.
- Reset mid-RUN: accept A=0x0F0F, B=0x00F1, drop reset at cycle 2 → no io_out_valid. The next operation A=3, B=4, Cin=1 gives sum=0x0008.
- WIDTH=4 build: random 1000 operations against a golden {cout,sum}=A+B+Cin with random out_ready → all match, latency 1.
